// File: rtl/rf_debug_access_pkg.sv
// Shared types for the register-file debug initiator: command encoding,
// FSM state encoding and the architectural register count.
package rf_debug_access_pkg;

  localparam int RF_DBG_NREGS = 32;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_DUMP  = 2'b10,
    CMD_RSVD  = 2'b11
  } rf_dbg_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HALT = 3'd1,
    ST_READ      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_RESP      = 3'd4,
    ST_DUMP_RD   = 3'd5,
    ST_DUMP_RSP  = 3'd6
  } rf_dbg_state_e;

endpackage

// File: rtl/rf_debug_access.sv
// Debug-side register-file initiator: halts the core, performs a single read/write
// (or, with RF_DEBUG_DUMP_EN defined, a full register dump) and returns responses.
module rf_debug_access
  import rf_debug_access_pkg::*;
#(
  parameter int NREGS = RF_DBG_NREGS
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [1:0]               req_cmd_i,
  input  logic [$clog2(NREGS)-1:0] req_addr_i,
  input  logic [31:0]              req_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [$clog2(NREGS)-1:0] rsp_addr_o,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     rsp_last_o,
  output logic                     halt_req_o,
  input  logic                     halted_i,
  output logic                     rf_write_en_o,
  output logic [$clog2(NREGS)-1:0] rf_addr_rd_o,
  output logic [31:0]              rf_data_rd_o,
  output logic [$clog2(NREGS)-1:0] rf_addr_rs1_o,
  input  logic [31:0]              rf_data_rs1_i
);

  localparam int AW = $clog2(NREGS);

  rf_dbg_state_e state_q;
  rf_dbg_cmd_e   cmd_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [AW-1:0] rsp_addr_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;
  logic          rsp_last_q;
  logic          halt_req_q;
  logic          rf_we_q;
  logic [AW-1:0] rf_addr_rd_q;
  logic [31:0]   rf_data_rd_q;
  logic [AW-1:0] rf_addr_rs1_q;
  logic          cmd_rsvd;

`ifdef RF_DEBUG_DUMP_EN
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  logic [AW-1:0] idx_q;
  assign cmd_rsvd = (req_cmd_i == CMD_RSVD);
`else
  assign cmd_rsvd = (req_cmd_i == CMD_RSVD) || (req_cmd_i == CMD_DUMP);
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      cmd_q         <= CMD_READ;
      addr_q        <= '0;
      data_q        <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_last_q    <= 1'b0;
      halt_req_q    <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_addr_rd_q  <= '0;
      rf_data_rd_q  <= '0;
      rf_addr_rs1_q <= '0;
`ifdef RF_DEBUG_DUMP_EN
      idx_q         <= '0;
`endif
    end else begin
      // Register-file ports are only driven during the single access cycle.
      rf_we_q       <= 1'b0;
      rf_addr_rd_q  <= '0;
      rf_data_rd_q  <= '0;
      rf_addr_rs1_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            cmd_q       <= rf_dbg_cmd_e'(req_cmd_i);
            addr_q      <= req_addr_i;
            data_q      <= req_data_i;
            req_ready_q <= 1'b0;
            rsp_addr_q  <= req_addr_i;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b1;
            if (cmd_rsvd) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              rsp_err_q  <= 1'b0;
              halt_req_q <= 1'b1;
              state_q    <= ST_WAIT_HALT;
`ifdef RF_DEBUG_DUMP_EN
              idx_q      <= '0;
`endif
            end
          end
        end
        ST_WAIT_HALT: begin
          if (halted_i) begin
            case (cmd_q)
              CMD_WRITE: begin
                state_q <= ST_WRITE;
                if (addr_q != '0) begin
                  rf_we_q      <= 1'b1;
                  rf_addr_rd_q <= addr_q;
                  rf_data_rd_q <= data_q;
                end
              end
`ifdef RF_DEBUG_DUMP_EN
              CMD_DUMP: begin
                state_q       <= ST_DUMP_RD;
                rf_addr_rs1_q <= idx_q;
              end
`endif
              default: begin
                state_q       <= ST_READ;
                rf_addr_rs1_q <= addr_q;
              end
            endcase
          end
        end
        ST_READ: begin
          rsp_data_q  <= rf_data_rs1_i;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_WRITE: begin
          rsp_err_q   <= (addr_q == '0);
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            halt_req_q  <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
`ifdef RF_DEBUG_DUMP_EN
        ST_DUMP_RD: begin
          rsp_addr_q  <= idx_q;
          rsp_data_q  <= rf_data_rs1_i;
          rsp_last_q  <= (idx_q == LAST_IDX);
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_DUMP_RSP;
        end
        ST_DUMP_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              rsp_addr_q  <= '0;
              rsp_data_q  <= '0;
              rsp_last_q  <= 1'b0;
              halt_req_q  <= 1'b0;
              req_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              idx_q         <= idx_q + AW'(1);
              rf_addr_rs1_q <= idx_q + AW'(1);
              state_q       <= ST_DUMP_RD;
            end
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_addr_o    = rsp_addr_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_last_o    = rsp_last_q;
  assign halt_req_o    = halt_req_q;
  assign rf_write_en_o = rf_we_q;
  assign rf_addr_rd_o  = rf_addr_rd_q;
  assign rf_data_rd_o  = rf_data_rd_q;
  assign rf_addr_rs1_o = rf_addr_rs1_q;

endmodule

// File: tb/tb_rf_debug_access.sv
// Directed bench for rf_debug_access with a behavioural register file
// (x0 reads zero, writes commit on negedge).
`timescale 1ns/1ps
module tb_rf_debug_access;
  import rf_debug_access_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = 2'b00;
  logic [4:0]  req_addr = 5'd0;
  logic [31:0] req_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic        halt_req;
  logic        halted = 1'b0;
  logic        rf_write_en;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
  logic [4:0]  rf_addr_rs1;
  logic [31:0] rf_data_rs1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int halt_cycles = 0;
  int rf_init = 1;
  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  rf_debug_access dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_addr_o(rsp_addr),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .rsp_last_o(rsp_last),
    .halt_req_o(halt_req), .halted_i(halted),
    .rf_write_en_o(rf_write_en), .rf_addr_rd_o(rf_addr_rd), .rf_data_rd_o(rf_data_rd),
    .rf_addr_rs1_o(rf_addr_rs1), .rf_data_rs1_i(rf_data_rs1)
  );

  always @(negedge clk) begin
    if (rf_init == 1) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
    end else if (rf_init == 2) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'(i * 17);
    end else if (rf_write_en) begin
      rf_mem[rf_addr_rd] <= rf_data_rd;
    end
  end
  assign rf_data_rs1 = (rf_addr_rs1 == 5'd0) ? 32'h0 : rf_mem[rf_addr_rs1];

  always @(posedge clk) begin
    if (rf_write_en) wr_pulses++;
    if (halt_req) halt_cycles++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [1:0] c, input logic [4:0] a, input logic [31:0] d);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_cmd = c; req_addr = a; req_data = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int maxc);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic finish_rsp(input string name);
    $display("txn %s: addr=%0d data=%h err=%b last=%b", name, rsp_addr, rsp_data, rsp_err, rsp_last);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, halt_req, req_ready} !== 3'b001) begin
      n_bad++; $display("FAIL %s_release: valid/halt/ready got %b want 001", name, {rsp_valid, halt_req, req_ready});
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; rf_init = 1;
    step(); step();
    n_cmp++;
    if ({req_ready, halt_req, rsp_valid, rsp_err, rsp_last, rf_write_en} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 100000", {req_ready, halt_req, rsp_valid, rsp_err, rsp_last, rf_write_en});
    end
    n_cmp++;
    if ({rsp_addr, rsp_data, rf_addr_rd, rf_data_rd, rf_addr_rs1} !== 79'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {rsp_addr, rsp_data, rf_addr_rd, rf_data_rd, rf_addr_rs1});
    end
    @(negedge clk); rstn = 1'b1; rf_init = 0;
    step();
  endtask

  task automatic test_write_read();
    int w0;
    halted = 1'b1;
    w0 = wr_pulses;
    send(CMD_WRITE, 5'd5, 32'hDEADBEEF);
    n_cmp++;
    if ({halt_req, rf_write_en} !== 2'b10) begin
      n_bad++; $display("FAIL wr_wait: halt/we got %b want 10", {halt_req, rf_write_en});
    end
    step();
    n_cmp++;
    if ({rf_write_en, rf_addr_rd, rf_data_rd} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL wr_access: got we=%b a=%0d d=%h want 1 5 deadbeef", rf_write_en, rf_addr_rd, rf_data_rd);
    end
    step();
    n_cmp++;
    if ({rsp_valid, rf_write_en, rsp_err, rsp_last, rsp_addr, rsp_data} !== {4'b1001, 5'd5, 32'h0}) begin
      n_bad++; $display("FAIL wr_rsp: got v=%b we=%b e=%b l=%b a=%0d d=%h", rsp_valid, rf_write_en, rsp_err, rsp_last, rsp_addr, rsp_data);
    end
    step();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_last, rsp_addr} !== {3'b101, 5'd5}) begin
      n_bad++; $display("FAIL wr_rsp_hold: got v=%b e=%b l=%b a=%0d", rsp_valid, rsp_err, rsp_last, rsp_addr);
    end
    finish_rsp("write_x5");
    n_cmp++;
    if (wr_pulses - w0 !== 1) begin
      n_bad++; $display("FAIL wr_pulse_count: got %0d want 1", wr_pulses - w0);
    end
    send(CMD_READ, 5'd5, 32'h0);
    step();
    n_cmp++;
    if (rf_addr_rs1 !== 5'd5) begin
      n_bad++; $display("FAIL rd_access: rs1 got %0d want 5", rf_addr_rs1);
    end
    step();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_last, rsp_addr, rsp_data} !== {3'b101, 5'd5, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL rd_rsp: got v=%b e=%b l=%b a=%0d d=%h want 1 0 1 5 deadbeef", rsp_valid, rsp_err, rsp_last, rsp_addr, rsp_data);
    end
    finish_rsp("read_x5");
  endtask

  task automatic test_write_x0();
    int w0;
    w0 = wr_pulses;
    send(CMD_WRITE, 5'd0, 32'h12345678);
    wait_rsp(10);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_last, rsp_data} !== {3'b111, 32'h0}) begin
      n_bad++; $display("FAIL wr_x0_rsp: got v=%b e=%b l=%b d=%h want 1 1 1 0", rsp_valid, rsp_err, rsp_last, rsp_data);
    end
    finish_rsp("write_x0");
    n_cmp++;
    if (wr_pulses !== w0) begin
      n_bad++; $display("FAIL wr_x0_no_pulse: got %0d pulses want 0", wr_pulses - w0);
    end
    send(CMD_READ, 5'd0, 32'h0);
    wait_rsp(10);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h0}) begin
      n_bad++; $display("FAIL rd_x0: got v=%b e=%b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_data);
    end
    finish_rsp("read_x0");
  endtask

  task automatic test_halt_wait();
    int n0;
    halted = 1'b0;
    send(CMD_READ, 5'd5, 32'h0);
    n0 = cyc - 1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({halt_req, rf_write_en, rf_addr_rs1, rsp_valid} !== {2'b10, 5'd0, 1'b0}) begin
        n_bad++; $display("FAIL halt_wait_%0d: halt=%b we=%b rs1=%0d v=%b", i, halt_req, rf_write_en, rf_addr_rs1, rsp_valid);
      end
      step();
    end
    halted = 1'b1;
    wait_rsp(20);
    n_cmp++;
    if (cyc - n0 !== 8 || rsp_valid !== 1'b1) begin
      n_bad++; $display("FAIL halt_latency: got %0d cycles (valid=%b) want 8", cyc - n0, rsp_valid);
    end
    n_cmp++;
    if (rsp_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL halt_rd_data: got %h want deadbeef", rsp_data);
    end
    finish_rsp("read_x5_slow");
  endtask

  task automatic test_reserved();
    int h0;
    h0 = halt_cycles;
    send(CMD_RSVD, 5'd7, 32'hFFFF_FFFF);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_last, halt_req, rsp_addr, rsp_data} !== {4'b1110, 5'd7, 32'h0}) begin
      n_bad++; $display("FAIL rsvd_rsp: got v=%b e=%b l=%b h=%b a=%0d d=%h", rsp_valid, rsp_err, rsp_last, halt_req, rsp_addr, rsp_data);
    end
    finish_rsp("rsvd");
`ifndef RF_DEBUG_DUMP_EN
    send(CMD_DUMP, 5'd3, 32'h0);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_last, halt_req, rsp_addr, rsp_data} !== {4'b1110, 5'd3, 32'h0}) begin
      n_bad++; $display("FAIL dump_off_rsp: got v=%b e=%b l=%b h=%b a=%0d d=%h", rsp_valid, rsp_err, rsp_last, halt_req, rsp_addr, rsp_data);
    end
    finish_rsp("dump_disabled");
`endif
    n_cmp++;
    if (halt_cycles !== h0) begin
      n_bad++; $display("FAIL rsvd_no_halt: halt high %0d cycles want 0", halt_cycles - h0);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    halted = 1'b0;
    send(CMD_READ, 5'd5, 32'h0);
    step(); step();
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, halt_req, rsp_valid, rf_write_en, rf_addr_rs1} !== {4'b1000, 5'd0}) begin
      n_bad++; $display("FAIL rst_wait_halt: got rdy=%b h=%b v=%b we=%b rs1=%0d", req_ready, halt_req, rsp_valid, rf_write_en, rf_addr_rs1);
    end
    @(negedge clk); rstn = 1'b1;
    step();
    halted = 1'b1;
    w0 = wr_pulses;
    send(CMD_WRITE, 5'd9, 32'hCAFEF00D);
    step();
    n_cmp++;
    if (rf_write_en !== 1'b1) begin
      n_bad++; $display("FAIL rst_we_pre: got %b want 1", rf_write_en);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({rf_write_en, halt_req, req_ready} !== 3'b001) begin
      n_bad++; $display("FAIL rst_we_cut: we/halt/rdy got %b want 001", {rf_write_en, halt_req, req_ready});
    end
    @(negedge clk); rstn = 1'b1;
    step();
    n_cmp++;
    if (wr_pulses !== w0) begin
      n_bad++; $display("FAIL rst_we_count: got %0d pulses want 0", wr_pulses - w0);
    end
    send(CMD_READ, 5'd9, 32'h0);
    wait_rsp(10);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h0}) begin
      n_bad++; $display("FAIL rst_rd_x9: got v=%b e=%b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_data);
    end
    finish_rsp("read_x9_after_rst");
    send(CMD_READ, 5'd5, 32'h0);
    wait_rsp(10);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL rst_rd_x5: got v=%b e=%b d=%h want 1 0 deadbeef", rsp_valid, rsp_err, rsp_data);
    end
    finish_rsp("read_x5_after_rst");
  endtask

`ifdef RF_DEBUG_DUMP_EN
  task automatic test_dump();
    int exp_idx;
    rf_init = 2;
    step();
    rf_init = 0;
    halted = 1'b1;
    send(CMD_DUMP, 5'd0, 32'h0);
    exp_idx = 0;
    for (int k = 0; k < 400 && exp_idx < 32; k++) begin
      rsp_ready = (k % 2 == 1);
      if (rsp_valid === 1'b1) begin
        n_cmp++;
        if ({rsp_addr, rsp_data, rsp_last, rsp_err} !== {5'(exp_idx), 32'(exp_idx * 17), (exp_idx == 31), 1'b0}) begin
          n_bad++; $display("FAIL dump_rsp_%0d: got a=%0d d=%h l=%b e=%b", exp_idx, rsp_addr, rsp_data, rsp_last, rsp_err);
        end
        if (rsp_ready) begin
          $display("txn dump: addr=%0d data=%h last=%b", rsp_addr, rsp_data, rsp_last);
          exp_idx++;
        end
      end
      step();
    end
    rsp_ready = 1'b0;
    n_cmp++;
    if (exp_idx !== 32) begin
      n_bad++; $display("FAIL dump_count: got %0d responses want 32", exp_idx);
    end
    n_cmp++;
    if ({rsp_valid, halt_req, req_ready} !== 3'b001) begin
      n_bad++; $display("FAIL dump_end: valid/halt/ready got %b want 001", {rsp_valid, halt_req, req_ready});
    end
    send(CMD_DUMP, 5'd0, 32'h0);
    wait_rsp(10);
    n_cmp++;
    if ({rsp_valid, rsp_addr, halt_req} !== {1'b1, 5'd0, 1'b1}) begin
      n_bad++; $display("FAIL dump2_first: got v=%b a=%0d h=%b", rsp_valid, rsp_addr, halt_req);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, halt_req, req_ready, rsp_last, rsp_addr, rsp_data} !== {4'b0010, 5'd0, 32'h0}) begin
      n_bad++; $display("FAIL rst_dump_rsp: got v=%b h=%b r=%b l=%b a=%0d d=%h", rsp_valid, halt_req, req_ready, rsp_last, rsp_addr, rsp_data);
    end
    @(negedge clk); rstn = 1'b1;
    step();
    send(CMD_READ, 5'd3, 32'h0);
    wait_rsp(10);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h33}) begin
      n_bad++; $display("FAIL rst_dump_rd_x3: got v=%b e=%b d=%h want 1 0 33", rsp_valid, rsp_err, rsp_data);
    end
    finish_rsp("read_x3_after_dump_rst");
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_write_x0();
    test_halt_wait();
    test_reserved();
    test_reset_mid();
`ifdef RF_DEBUG_DUMP_EN
    test_dump();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
